hcms_display_ctrl: RTL and testbench

HCMS_DISPLAY_CTRL -- requirements
Module: hcms_display_ctrl

---
 rtl/hcms_display_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_hcms_display_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcms_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hcms_display_ctrl: HCMS 4-digit hex display sequencer (init, bright, dots)|
// | Optional HCMS_AUTO_REFRESH_EN: periodic redraw.           Rev 1.0        |
// +--------------------------------------------------------------------------+
module hcms_display_ctrl #(
  parameter int RESET_CYCLES   = 16,
  parameter int REFRESH_PERIOD = 100000
) (
  input  logic       i_clk,
  input  logic       r_reset,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_addr,
  input  logic [3:0] i_wr_char,
  input  logic       i_bright_wr,
  input  logic [3:0] i_bright,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_rs,
  output logic       o_frame,
  output logic       o_disp_nreset,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    CW1      = 3'd1,
    CW0      = 3'd2,
    IDLE     = 3'd3,
    DATA     = 3'd4,
    LATCH    = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(RESET_CYCLES);

  state_t           r_state;
  state_t           r_ret;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0][3:0]  r_buf;
  logic [3:0]       r_bright;
  logic             r_dirty;
  logic             r_bright_pend;
  logic [1:0]       r_pos;
  logic [2:0]       r_col;
  logic [7:0]       r_byte;
  logic             r_valid;
  logic             r_rs;
  logic             r_frame;
  logic             r_nreset;

  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_npos;
  logic [2:0]       w_ncol;
  logic             w_refresh_tick;

  // Column-major 5x7 glyphs, bit 0 = top row, bit 7 always clear.
  function automatic logic [7:0] font_col(input logic [3:0] ch, input logic [2:0] col);
    logic [39:0] g;
    case (ch)
      4'h0:    g = 40'h3E_51_49_45_3E;
      4'h1:    g = 40'h00_42_7F_40_00;
      4'h2:    g = 40'h42_61_51_49_46;
      4'h3:    g = 40'h21_41_45_4B_31;
      4'h4:    g = 40'h18_14_12_7F_10;
      4'h5:    g = 40'h27_45_45_45_39;
      4'h6:    g = 40'h3C_4A_49_49_30;
      4'h7:    g = 40'h01_71_09_05_03;
      4'h8:    g = 40'h36_49_49_49_36;
      4'h9:    g = 40'h06_49_49_29_1E;
      4'hA:    g = 40'h7E_11_11_11_7E;
      4'hB:    g = 40'h7F_49_49_49_36;
      4'hC:    g = 40'h3E_41_41_41_22;
      4'hD:    g = 40'h7F_41_41_22_1C;
      4'hE:    g = 40'h7F_49_49_49_41;
      default: g = 40'h7F_09_09_09_01;
    endcase
    case (col)
      3'd0:    font_col = g[39:32];
      3'd1:    font_col = g[31:24];
      3'd2:    font_col = g[23:16];
      3'd3:    font_col = g[15:8];
      default: font_col = g[7:0];
    endcase
  endfunction

  assign w_accept = r_valid && i_byte_ready;
  assign w_last   = (r_pos == 2'd0) && (r_col == 3'd4);
  assign w_npos   = (r_col == 3'd4) ? r_pos - 2'd1 : r_pos;
  assign w_ncol   = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;

`ifdef HCMS_AUTO_REFRESH_EN
  localparam int REF_W = $clog2(REFRESH_PERIOD);
  logic [REF_W-1:0] r_refresh_cnt;

  assign w_refresh_tick = (r_state != RST_HOLD) &&
                          (r_refresh_cnt == REF_W'(REFRESH_PERIOD - 1));

  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      r_refresh_cnt <= '0;
    end else if (r_state != RST_HOLD) begin
      r_refresh_cnt <= w_refresh_tick ? '0 : r_refresh_cnt + 1'b1;
    end
  end
`else
  // Period is meaningless when auto-refresh is compiled out.
  assign w_refresh_tick = 1'b0 & (REFRESH_PERIOD != 0);
`endif

  // Every group's first byte is loaded on the transition into its state, so
  // o_frame rises together with o_byte_valid and LATCH is a single low cycle.
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      r_state       <= RST_HOLD;
      r_ret         <= IDLE;
      r_cnt         <= '0;
      r_buf         <= '0;
      r_bright      <= 4'hF;
      r_dirty       <= 1'b1;
      r_bright_pend <= 1'b0;
      r_pos         <= 2'd0;
      r_col         <= 3'd0;
      r_byte        <= 8'h00;
      r_valid       <= 1'b0;
      r_rs          <= 1'b0;
      r_frame       <= 1'b0;
      r_nreset      <= 1'b0;
    end else begin
      case (r_state)
        RST_HOLD: begin
          if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
            r_nreset <= 1'b1;
            r_state  <= CW1;
            r_byte   <= 8'h81;
            r_rs     <= 1'b1;
            r_valid  <= 1'b1;
            r_frame  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CW1, CW0: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_frame <= 1'b0;
            r_ret   <= (r_state == CW1) ? CW0 : IDLE;
            r_state <= LATCH;
          end
        end
        IDLE: begin
          if (r_bright_pend) begin
            r_state       <= CW0;
            r_byte        <= {4'b0100, r_bright};
            r_rs          <= 1'b1;
            r_valid       <= 1'b1;
            r_frame       <= 1'b1;
            r_bright_pend <= 1'b0;
          end else if (r_dirty) begin
            r_state <= DATA;
            r_pos   <= 2'd3;
            r_col   <= 3'd0;
            r_byte  <= font_col(r_buf[3], 3'd0);
            r_rs    <= 1'b0;
            r_valid <= 1'b1;
            r_frame <= 1'b1;
            r_dirty <= 1'b0;
          end
        end
        DATA: begin
          if (w_accept) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_frame <= 1'b0;
              r_ret   <= IDLE;
              r_state <= LATCH;
            end else begin
              r_pos  <= w_npos;
              r_col  <= w_ncol;
              r_byte <= font_col(r_buf[w_npos], w_ncol);
            end
          end
        end
        LATCH: begin
          r_state <= r_ret;
          if (r_ret == CW0) begin
            r_byte        <= {4'b0100, r_bright};
            r_rs          <= 1'b1;
            r_valid       <= 1'b1;
            r_frame       <= 1'b1;
            r_bright_pend <= 1'b0;
          end
        end
        default: r_state <= RST_HOLD;
      endcase

      // Host requests come last so a set always beats a same-cycle clear.
      if (i_wr_en) begin
        r_buf[i_wr_addr] <= i_wr_char;
        r_dirty          <= 1'b1;
      end
      if (w_refresh_tick) begin
        r_dirty <= 1'b1;
      end
      if (i_bright_wr) begin
        r_bright      <= i_bright;
        r_bright_pend <= 1'b1;
      end
    end
  end

  assign o_byte        = r_byte;
  assign o_byte_valid  = r_valid;
  assign o_rs          = r_rs;
  assign o_frame       = r_frame;
  assign o_disp_nreset = r_nreset;
  assign o_busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hcms_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hcms_display_ctrl: self-checking bench with a frame-level display model|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hcms_display_ctrl;

  logic       clk = 1'b0;
  logic       r_reset = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [1:0] i_wr_addr = 2'd0;
  logic [3:0] i_wr_char = 4'd0;
  logic       i_bright_wr = 1'b0;
  logic [3:0] i_bright = 4'd0;
  logic       i_byte_ready = 1'b1;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_rs;
  logic       o_frame;
  logic       o_disp_nreset;
  logic       o_busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  hcms_display_ctrl #(.RESET_CYCLES(16), .REFRESH_PERIOD(1000)) dut (
    .i_clk(clk), .r_reset(r_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_char(i_wr_char), .i_bright_wr(i_bright_wr), .i_bright(i_bright),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_rs(o_rs), .o_frame(o_frame), .o_disp_nreset(o_disp_nreset), .o_busy(o_busy)
  );

  // Reference glyph table: 16 hex digits x 5 columns, bit 0 = top row.
  logic [7:0] font [0:79] = '{
    8'h3E,8'h51,8'h49,8'h45,8'h3E,  8'h00,8'h42,8'h7F,8'h40,8'h00,
    8'h42,8'h61,8'h51,8'h49,8'h46,  8'h21,8'h41,8'h45,8'h4B,8'h31,
    8'h18,8'h14,8'h12,8'h7F,8'h10,  8'h27,8'h45,8'h45,8'h45,8'h39,
    8'h3C,8'h4A,8'h49,8'h49,8'h30,  8'h01,8'h71,8'h09,8'h05,8'h03,
    8'h36,8'h49,8'h49,8'h49,8'h36,  8'h06,8'h49,8'h49,8'h29,8'h1E,
    8'h7E,8'h11,8'h11,8'h11,8'h7E,  8'h7F,8'h49,8'h49,8'h49,8'h36,
    8'h3E,8'h41,8'h41,8'h41,8'h22,  8'h7F,8'h41,8'h41,8'h22,8'h1C,
    8'h7F,8'h49,8'h49,8'h49,8'h41,  8'h7F,8'h09,8'h09,8'h09,8'h01
  };

  // Display model: what the four digits should read, leftmost = index 0.
  int mbuf [4];

  // Observed traffic: accepted {rs,byte} and cumulative byte count at each frame close.
  logic [8:0] byte_q [$];
  int         grp_end_q [$];
  int         lowrun_q [$];
  int         rise_q [$];
  logic       prev_frame = 1'b0;
  int         lowrun = 0;

  always @(negedge clk) begin
    if (r_reset) begin
      prev_frame = 1'b0;
      lowrun = 0;
    end else begin
      if (o_byte_valid && i_byte_ready) byte_q.push_back({o_rs, o_byte});
      if (prev_frame && !o_frame) grp_end_q.push_back(byte_q.size());
      if (o_frame && !prev_frame) begin
        lowrun_q.push_back(lowrun);
        rise_q.push_back(cyc);
        lowrun = 0;
      end
      if (!o_frame) lowrun++;
      prev_frame = o_frame;
    end
  end

  // Display order is rightmost digit first, each digit left column first.
  function automatic logic [8:0] exp_data(input int k);
    return {1'b0, font[mbuf[3 - k / 5] * 5 + k % 5]};
  endfunction

  function automatic int gstart(input int g);
    return (g == 0) ? 0 : grp_end_q[g - 1];
  endfunction

  function automatic int gsize(input int g);
    return grp_end_q[g] - gstart(g);
  endfunction

  task automatic clear_obs();
    byte_q.delete();
    grp_end_q.delete();
    lowrun_q.delete();
    rise_q.delete();
    for (int i = 0; i < 4; i++) mbuf[i] = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] c);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_char = c;
    mbuf[a] = c;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!o_busy && !o_frame) quiet++; else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_bytes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (byte_q.size() >= target) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lows = 0;
    bit ok;
    r_reset = 1'b1; i_byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (o_disp_nreset !== 1'b0) begin n_fail++; $display("FAIL rst_nreset: got %b want 0", o_disp_nreset); end
    n_cmp++; if (o_byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_byte_valid); end
    n_cmp++; if (o_frame !== 1'b0) begin n_fail++; $display("FAIL rst_frame: got %b want 0", o_frame); end
    n_cmp++; if (o_rs !== 1'b0) begin n_fail++; $display("FAIL rst_rs: got %b want 0", o_rs); end
    n_cmp++; if (o_byte !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %h want 00", o_byte); end
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", o_busy); end
    @(posedge clk); #1;
    r_reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_disp_nreset) break;
      lows++;
    end
    n_cmp++; if (lows !== 16) begin n_fail++; $display("FAIL nreset_low_cycles: got %0d want 16", lows); end
    wait_idle(500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL init_idle_timeout: got %b want 1", ok); end
    n_cmp++; if (grp_end_q.size() !== 3) begin n_fail++; $display("FAIL init_groups: got %0d want 3", grp_end_q.size()); end
    if (grp_end_q.size() >= 3) begin
      n_cmp++; if (gsize(0) !== 1 || byte_q[0] !== 9'h181) begin n_fail++; $display("FAIL init_cw1: got size %0d byte %h want 1 181", gsize(0), byte_q[0]); end
      n_cmp++; if (gsize(1) !== 1 || byte_q[1] !== 9'h14F) begin n_fail++; $display("FAIL init_cw0: got size %0d byte %h want 1 14f", gsize(1), byte_q[1]); end
      n_cmp++; if (lowrun_q[1] !== 1) begin n_fail++; $display("FAIL latch_width: got %0d want 1", lowrun_q[1]); end
      n_cmp++; if (gsize(2) !== 20) begin n_fail++; $display("FAIL init_data_len: got %0d want 20", gsize(2)); end
      for (int k = 0; k < 20; k++) begin
        n_cmp++; if (byte_q[2 + k] !== exp_data(k)) begin n_fail++; $display("FAIL init_data[%0d]: got %h want %h", k, byte_q[2 + k], exp_data(k)); end
      end
    end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_after: got %b want 0", o_busy); end
  endtask

  task automatic test_write_pattern();
    bit ok;
    int g;
    wr(2'd0, 4'hA);
    wr(2'd3, 4'h1);
    wait_idle(300, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL pattern_idle_timeout: got %b want 1", ok); end
    g = grp_end_q.size() - 1;
    n_cmp++; if (gsize(g) !== 20) begin n_fail++; $display("FAIL pattern_len: got %0d want 20", gsize(g)); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (byte_q[gstart(g) + k] !== {1'b0, font[5 + k]}) begin n_fail++; $display("FAIL pattern_glyph1[%0d]: got %h want %h", k, byte_q[gstart(g) + k], {1'b0, font[5 + k]}); end
      n_cmp++; if (byte_q[gstart(g) + 15 + k] !== {1'b0, font[50 + k]}) begin n_fail++; $display("FAIL pattern_glyphA[%0d]: got %h want %h", k, byte_q[gstart(g) + 15 + k], {1'b0, font[50 + k]}); end
    end
  endtask

  task automatic test_random_writes();
    bit ok;
    int g, n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) wr(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      wait_idle(400, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_idle_timeout[%0d]: got %b want 1", it, ok); end
      g = grp_end_q.size() - 1;
      n_cmp++; if (gsize(g) !== 20) begin n_fail++; $display("FAIL rand_len[%0d]: got %0d want 20", it, gsize(g)); end
      for (int k = 0; k < 20; k++) begin
        n_cmp++; if (byte_q[gstart(g) + k] !== exp_data(k)) begin n_fail++; $display("FAIL rand_data[%0d][%0d]: got %h want %h", it, k, byte_q[gstart(g) + k], exp_data(k)); end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int g0, base;
    logic [10:0] ref_v, now_v;
    logic [3:0] nc;
    g0 = grp_end_q.size();
    base = byte_q.size();
    wr(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)));
    wait_bytes(base + 6, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_start_timeout: got %b want 1", ok); end
    i_byte_ready = 1'b0;
    @(negedge clk);
    ref_v = {o_byte_valid, o_frame, o_rs, o_byte};
    nc = 4'($urandom_range(0, 15));
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      i_wr_en = (i == 3); i_wr_addr = 2'd0; i_wr_char = nc;
      if (i == 3) mbuf[0] = nc;
      @(negedge clk);
      now_v = {o_byte_valid, o_frame, o_rs, o_byte};
      n_cmp++; if (now_v !== ref_v || ref_v[10:9] !== 2'b11) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h with valid,frame=11", i, now_v, ref_v); end
    end
    @(posedge clk); #1;
    i_wr_en = 1'b0; i_byte_ready = 1'b1;
    wait_idle(400, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_idle_timeout: got %b want 1", ok); end
    n_cmp++; if (grp_end_q.size() < g0 + 2) begin n_fail++; $display("FAIL stall_refollow: got %0d frames want >= %0d", grp_end_q.size() - g0, 2); end
    if (grp_end_q.size() >= g0 + 2) begin
      n_cmp++; if (gsize(g0) !== 20) begin n_fail++; $display("FAIL stall_len: got %0d want 20", gsize(g0)); end
      for (int k = 0; k < 20; k++) begin
        n_cmp++; if (byte_q[gstart(g0) + k] !== exp_data(k)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", k, byte_q[gstart(g0) + k], exp_data(k)); end
        n_cmp++; if (byte_q[gstart(g0 + 1) + k] !== exp_data(k)) begin n_fail++; $display("FAIL stall_refr_data[%0d]: got %h want %h", k, byte_q[gstart(g0 + 1) + k], exp_data(k)); end
      end
    end
  endtask

  task automatic test_bright();
    bit ok;
    int g0;
    logic [3:0] bv;
    for (int it = 0; it < 2; it++) begin
      bv = (it == 0) ? 4'h3 : 4'($urandom_range(0, 15));
      g0 = grp_end_q.size();
      i_bright_wr = 1'b1; i_bright = bv;
      i_wr_en = 1'b1; i_wr_addr = 2'($urandom_range(0, 3)); i_wr_char = 4'($urandom_range(0, 15));
      mbuf[i_wr_addr] = i_wr_char;
      @(posedge clk); #1;
      i_bright_wr = 1'b0; i_wr_en = 1'b0;
      wait_idle(300, ok);
      n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bright_idle_timeout[%0d]: got %b want 1", it, ok); end
      n_cmp++; if (grp_end_q.size() < g0 + 2) begin n_fail++; $display("FAIL bright_groups[%0d]: got %0d want >= 2", it, grp_end_q.size() - g0); end
      if (grp_end_q.size() >= g0 + 2) begin
        n_cmp++; if (gsize(g0) !== 1 || byte_q[gstart(g0)] !== {1'b1, 4'h4, bv}) begin n_fail++; $display("FAIL bright_cw0[%0d]: got size %0d byte %h want 1 %h", it, gsize(g0), byte_q[gstart(g0)], {1'b1, 4'h4, bv}); end
        for (int k = 0; k < 20; k++) begin
          n_cmp++; if (byte_q[gstart(g0 + 1) + k] !== exp_data(k)) begin n_fail++; $display("FAIL bright_data[%0d][%0d]: got %h want %h", it, k, byte_q[gstart(g0 + 1) + k], exp_data(k)); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base, lows = 0;
    base = byte_q.size();
    wr(2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
    wait_bytes(base + 7, 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_start_timeout: got %b want 1", ok); end
    r_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({o_frame, o_byte_valid, o_disp_nreset} !== 3'b000) begin n_fail++; $display("FAIL midrst_drop: got frame,valid,nreset=%b want 000", {o_frame, o_byte_valid, o_disp_nreset}); end
    @(posedge clk); #1;
    r_reset = 1'b0;
    clear_obs();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_disp_nreset) break;
      lows++;
    end
    n_cmp++; if (lows !== 16) begin n_fail++; $display("FAIL midrst_nreset_low: got %0d want 16", lows); end
    wait_idle(500, ok);
    n_cmp++; if (grp_end_q.size() !== 3) begin n_fail++; $display("FAIL midrst_groups: got %0d want 3", grp_end_q.size()); end
    if (grp_end_q.size() >= 3) begin
      n_cmp++; if (byte_q[0] !== 9'h181 || byte_q[1] !== 9'h14F) begin n_fail++; $display("FAIL midrst_ctrl: got %h %h want 181 14f", byte_q[0], byte_q[1]); end
      for (int k = 0; k < 20; k++) begin
        n_cmp++; if (byte_q[2 + k] !== exp_data(k)) begin n_fail++; $display("FAIL midrst_data[%0d]: got %h want %h", k, byte_q[2 + k], exp_data(k)); end
      end
    end
  endtask

  task automatic test_auto_refresh();
    bit ok;
    int n0;
    wait_idle(300, ok);
`ifdef HCMS_AUTO_REFRESH_EN
    n0 = rise_q.size();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rise_q.size() >= n0 + 2) begin ok = 1'b1; break; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL refresh_timeout: got %0d frames want 2", rise_q.size() - n0); end
    if (ok) begin
      n_cmp++; if (rise_q[n0 + 1] - rise_q[n0] !== 1000) begin n_fail++; $display("FAIL refresh_period: got %0d want 1000", rise_q[n0 + 1] - rise_q[n0]); end
    end
    wait_idle(300, ok);
    n_cmp++; if (byte_q[byte_q.size() - 20] !== exp_data(0) || byte_q[byte_q.size() - 1] !== exp_data(19)) begin n_fail++; $display("FAIL refresh_data: got %h..%h want %h..%h", byte_q[byte_q.size() - 20], byte_q[byte_q.size() - 1], exp_data(0), exp_data(19)); end
`else
    n0 = grp_end_q.size();
    repeat (2500) @(negedge clk);
    n_cmp++; if (grp_end_q.size() !== n0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL no_refresh: got %0d new frames busy %b want 0 0", grp_end_q.size() - n0, o_busy); end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_write_pattern();
    test_random_writes();
    test_stall();
    test_bright();
    test_reset_mid();
    test_auto_refresh();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
